// File: rtl/match_filter_ctrl_if.sv
// Host serial register bus for the match filter sequencer.
// Signals: serial_strobe (write strobe), serial_addr[6:0], serial_data[31:0].
interface match_filter_ctrl_if;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;

    modport master (
        output serial_strobe,
        output serial_addr,
        output serial_data
    );

    modport slave (
        input serial_strobe,
        input serial_addr,
        input serial_data
    );
endinterface

// File: rtl/match_filter_ctrl.sv
// Host-side sequencer for the correlating match filter: shadow config bank,
// quiet-window commit into cdata/cstate/cwrite, rxstrobe gating, match debounce.
// Ports: clk, reset (async, active-low), host (serial register bus),
//   rxstrobe_in/out, mf_cdata/mf_cstate/mf_cwrite, mf_valid/mf_match,
//   match_event, match_count, drop_count, commit_busy, debugbus.
// Option macro MFCTRL_DIRTY_ONLY_EN: commit loads only words written since
//   their last load.
module match_filter_ctrl #(
    parameter logic [6:0] BASE_ADDR   = 7'd64,
    parameter int         BUSY_CYCLES = 8,
    parameter int         HOLDOFF     = 16
) (
    input  logic               clk,
    input  logic               reset,
    match_filter_ctrl_if.slave host,
    input  logic               rxstrobe_in,
    output logic               rxstrobe_out,
    output logic [31:0]        mf_cdata,
    output logic [2:0]         mf_cstate,
    output logic               mf_cwrite,
    input  logic               mf_valid,
    input  logic               mf_match,
    output logic               match_event,
    output logic [15:0]        match_count,
    output logic [15:0]        drop_count,
    output logic               commit_busy,
    output logic [15:0]        debugbus
);

    localparam int BW = (BUSY_CYCLES < 256) ? 8 : $clog2(BUSY_CYCLES + 1);
    localparam int HW = (HOLDOFF < 256) ? 8 : $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_QUIET = 2'd1,
        LOAD       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic          pending;
    logic          enable;
    logic [BW-1:0] busy_cnt;
    logic [HW-1:0] holdoff;
    logic [31:0]   shadow [8];

    logic [6:0]    off;
    logic          wr_shadow;
    logic          wr_ctrl;
    logic [2:0]    wr_idx;
    logic          commit;
    logic          clr;
    logic          drop;
    logic          hit;
    logic [31:0]   load_data;

    logic [2:0]    first_idx;
    logic [2:0]    next_idx;
    logic          first_ok;
    logic          next_ok;

    // Addresses below BASE wrap to large offsets and fall outside both ranges.
    assign off       = host.serial_addr - BASE_ADDR;
    assign wr_shadow = host.serial_strobe && (off < 7'd8);
    assign wr_ctrl   = host.serial_strobe && (off == 7'd8);
    assign wr_idx    = off[2:0];
    assign commit    = wr_ctrl && host.serial_data[0];
    assign clr       = wr_ctrl && host.serial_data[2];

    assign rxstrobe_out = rxstrobe_in && enable && (state == IDLE);
    assign drop         = rxstrobe_in && !rxstrobe_out;
    assign hit          = mf_valid && mf_match && (holdoff == '0);

    // A host write landing on the word being loaded this cycle is forwarded,
    // so a not-yet-loaded word always goes out with its newest value.
    assign load_data = (wr_shadow && (wr_idx == idx)) ? host.serial_data
                                                      : shadow[idx];

`ifdef MFCTRL_DIRTY_ONLY_EN
    logic [7:0] dirty;
    logic [7:0] wr_bit;
    logic [7:0] avail;
    logic [7:0] done_bit;

    // Descending scan so the lowest qualifying index is the one kept.
    always_comb begin
        wr_bit    = wr_shadow ? (8'd1 << wr_idx) : 8'd0;
        avail     = dirty | wr_bit;
        done_bit  = (state == LOAD) ? (8'd1 << idx) : 8'd0;
        first_idx = 3'd0;
        first_ok  = 1'b0;
        next_idx  = 3'd0;
        next_ok   = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (avail[i]) begin
                first_idx = 3'(i);
                first_ok  = 1'b1;
            end
            if (avail[i] && (i > int'(idx))) begin
                next_idx = 3'(i);
                next_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty <= 8'd0;
        end else begin
            dirty <= avail & ~done_bit;
        end
    end
`else
    assign first_idx = 3'd0;
    assign first_ok  = 1'b1;
    assign next_idx  = idx + 3'd1;
    assign next_ok   = (idx != 3'd7);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 32'd0;
            end
        end else if (wr_shadow) begin
            shadow[wr_idx] <= host.serial_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            pending     <= 1'b0;
            commit_busy <= 1'b0;
            mf_cwrite   <= 1'b0;
            mf_cstate   <= 3'd0;
            mf_cdata    <= 32'd0;
        end else begin
            mf_cwrite <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (commit) begin
                        state       <= WAIT_QUIET;
                        commit_busy <= 1'b1;
                    end
                end
                WAIT_QUIET: begin
                    if (commit) pending <= 1'b1;
                    if (busy_cnt == '0) begin
                        if (first_ok) begin
                            state <= LOAD;
                            idx   <= first_idx;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (commit) pending <= 1'b1;
                    mf_cwrite <= 1'b1;
                    mf_cstate <= idx;
                    mf_cdata  <= load_data;
                    if (next_ok) idx   <= next_idx;
                    else         state <= DONE;
                end
                DONE: begin
                    // A commit arriving in this very cycle merges into pending.
                    if (pending || commit) begin
                        pending <= 1'b0;
                        state   <= WAIT_QUIET;
                    end else begin
                        state       <= IDLE;
                        commit_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable      <= 1'b0;
            busy_cnt    <= '0;
            holdoff     <= '0;
            match_event <= 1'b0;
            match_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            if (wr_ctrl) enable <= host.serial_data[1];

            if (rxstrobe_out)         busy_cnt <= BW'(BUSY_CYCLES);
            else if (busy_cnt != '0)  busy_cnt <= busy_cnt - 1'b1;

            if (hit)                                 holdoff <= HW'(HOLDOFF);
            else if (rxstrobe_out && holdoff != '0)  holdoff <= holdoff - 1'b1;

            match_event <= hit;

            if (clr)                                  match_count <= 16'd0;
            else if (hit && match_count != 16'hFFFF)  match_count <= match_count + 16'd1;

            if (clr)                                  drop_count <= 16'd0;
            else if (drop && drop_count != 16'hFFFF)  drop_count <= drop_count + 16'd1;
        end
    end

    assign debugbus = {state, idx, pending, commit_busy, enable, busy_cnt[7:0]};

endmodule

// File: tb/tb_match_filter_ctrl.sv
// Testbench for match_filter_ctrl: scenario tasks plus randomized strobe/match
// traffic checked against a behavioural model of counters and holdoff.
module tb_match_filter_ctrl;

    localparam logic [6:0] BASE = 7'd64;
    localparam int         BUSY = 8;
    localparam int         HOLD = 16;
`ifdef MFCTRL_DIRTY_ONLY_EN
    localparam bit FULL_LOAD = 1'b0;
`else
    localparam bit FULL_LOAD = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxstrobe_in = 1'b0;
    logic        mf_valid = 1'b0;
    logic        mf_match = 1'b0;
    logic        rxstrobe_out;
    logic [31:0] mf_cdata;
    logic [2:0]  mf_cstate;
    logic        mf_cwrite;
    logic        match_event;
    logic [15:0] match_count;
    logic [15:0] drop_count;
    logic        commit_busy;
    logic [15:0] debugbus;

    match_filter_ctrl_if bus ();

    match_filter_ctrl #(
        .BASE_ADDR   (BASE),
        .BUSY_CYCLES (BUSY),
        .HOLDOFF     (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (bus),
        .rxstrobe_in  (rxstrobe_in),
        .rxstrobe_out (rxstrobe_out),
        .mf_cdata     (mf_cdata),
        .mf_cstate    (mf_cstate),
        .mf_cwrite    (mf_cwrite),
        .mf_valid     (mf_valid),
        .mf_match     (mf_match),
        .match_event  (match_event),
        .match_count  (match_count),
        .drop_count   (drop_count),
        .commit_busy  (commit_busy),
        .debugbus     (debugbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // cwrite monitor, sampled on the falling edge
    int          wq_cyc [$];
    logic [2:0]  wq_st [$];
    logic [31:0] wq_d [$];

    always @(negedge clk) begin
        if (mf_cwrite === 1'b1) begin
            wq_cyc.push_back(cyc);
            wq_st.push_back(mf_cstate);
            wq_d.push_back(mf_cdata);
        end
    end

    // host write log: shadow word i at edge e is the last write at or before e
    int          lg_cyc [$];
    logic [2:0]  lg_idx [$];
    logic [31:0] lg_d [$];

    bit en_m = 1'b0;
    int drop_m = 0;
    int match_m = 0;
    int fwd_since = 1000;

    function automatic logic [31:0] exp_word(input logic [2:0] i, input int e);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < lg_d.size(); k++) begin
            if (lg_idx[k] == i && lg_cyc[k] <= e) v = lg_d[k];
        end
        return v;
    endfunction

    task automatic clear_wq();
        wq_cyc.delete();
        wq_st.delete();
        wq_d.delete();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        logic [6:0] o;
        bus.serial_strobe = 1'b1;
        bus.serial_addr   = a;
        bus.serial_data   = d;
        @(posedge clk); #1;
        bus.serial_strobe = 1'b0;
        o = a - BASE;
        if (o < 7'd8) begin
            lg_cyc.push_back(cyc);
            lg_idx.push_back(o[2:0]);
            lg_d.push_back(d);
        end
        if (o == 7'd8) begin
            en_m = d[1];
            if (d[2]) begin
                drop_m = 0;
                match_m = 0;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (commit_busy === 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (commit_busy !== 1'b0)
            $display("FAIL %s timeout: commit_busy=%b want 0", name, commit_busy);
        else passed++;
    endtask

    // One cycle of strobe/match/control traffic with the model stepped alongside.
    task automatic drive_cycle(input bit rx, input bit v, input bit m,
                               input bit ctl, input logic [2:0] cb,
                               output bit evt, output bit rx_exp,
                               output logic rx_obs);
        bit fwd, hit;
        rxstrobe_in = rx;
        mf_valid = v;
        mf_match = m;
        bus.serial_strobe = ctl;
        bus.serial_addr = BASE + 7'd8;
        bus.serial_data = {29'd0, cb};
        fwd = rx && en_m;
        hit = v && m && (fwd_since >= HOLD);
        @(negedge clk);
        rx_obs = rxstrobe_out;
        rx_exp = fwd;
        @(posedge clk); #1;
        rxstrobe_in = 1'b0;
        mf_valid = 1'b0;
        mf_match = 1'b0;
        bus.serial_strobe = 1'b0;
        if (hit) begin
            fwd_since = 0;
            if (match_m < 65535) match_m++;
        end else if (fwd && fwd_since < 1000) begin
            fwd_since++;
        end
        if (rx && !en_m && drop_m < 65535) drop_m++;
        if (ctl) begin
            en_m = cb[1];
            if (cb[2]) begin
                drop_m = 0;
                match_m = 0;
            end
        end
        evt = hit;
    endtask

    task automatic test_reset();
        bus.serial_strobe = 1'b0;
        bus.serial_addr = 7'd0;
        bus.serial_data = 32'd0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        rxstrobe_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({mf_cwrite, mf_cstate, mf_cdata} !== 36'd0)
            $display("FAIL reset_cfg: got %b/%h/%h want 0", mf_cwrite, mf_cstate, mf_cdata);
        else passed++;
        checks++;
        if ({match_event, match_count, drop_count} !== 33'd0)
            $display("FAIL reset_cnt: got %b/%h/%h want 0", match_event, match_count, drop_count);
        else passed++;
        checks++;
        if ({commit_busy, rxstrobe_out} !== 2'd0)
            $display("FAIL reset_busy: got %b/%b want 0", commit_busy, rxstrobe_out);
        else passed++;
        checks++;
        if (debugbus !== 16'd0)
            $display("FAIL reset_debug: got %h want 0", debugbus);
        else passed++;
        rxstrobe_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_commit();
        int c, fall, n;
        for (int i = 0; i < 8; i++) wr(BASE + 7'(i), 32'h1000_0000 + i);
        clear_wq();
        wr(BASE + 7'd8, 32'h3);
        c = cyc;
        checks++;
        if (commit_busy !== 1'b1)
            $display("FAIL idle_busy_rise: got %b want 1", commit_busy);
        else passed++;
        wait_idle("idle_commit");
        fall = cyc;
        n = wq_cyc.size();
        checks++;
        if (n !== 8) $display("FAIL idle_count: got %0d want 8", n);
        else passed++;
        for (int k = 0; k < n && k < 8; k++) begin
            checks++;
            if (wq_cyc[k] !== c + 2 + k || wq_st[k] !== 3'(k))
                $display("FAIL idle_slot%0d: cyc %0d st %0d want cyc %0d st %0d",
                         k, wq_cyc[k], wq_st[k], c + 2 + k, k);
            else passed++;
            checks++;
            if (wq_d[k] !== exp_word(wq_st[k], wq_cyc[k]))
                $display("FAIL idle_data%0d: got %h want %h",
                         k, wq_d[k], exp_word(wq_st[k], wq_cyc[k]));
            else passed++;
        end
        checks++;
        if (fall !== c + 10) $display("FAIL idle_busy_fall: got %0d want %0d", fall, c + 10);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mf_cstate !== 3'd7 || mf_cdata !== exp_word(3'd7, cyc))
            $display("FAIL idle_hold: got %0d/%h want 7/%h", mf_cstate, mf_cdata, exp_word(3'd7, cyc));
        else passed++;
    endtask

    task automatic test_commit_during_activity();
        int c0 = 0, cc = 0, first, want;
        clear_wq();
        bus.serial_addr = BASE + 7'd8;
        bus.serial_data = 32'h3;
        for (int k = 0; k < 10; k++) begin
            rxstrobe_in = (k == 0 || k == 4 || k == 6);
            bus.serial_strobe = (k == 2);
            @(posedge clk); #1;
            if (k == 0) c0 = cyc;
            if (k == 2) cc = cyc;
            if (k == 4 || k == 6) drop_m++;
        end
        rxstrobe_in = 1'b0;
        bus.serial_strobe = 1'b0;
        wait_idle("busy_commit");
        checks++;
        if (wq_cyc.size() !== 8) $display("FAIL busy_count: got %0d want 8", wq_cyc.size());
        else passed++;
        want = (cc + 2 > c0 + BUSY + 2) ? cc + 2 : c0 + BUSY + 2;
        first = (wq_cyc.size() > 0) ? wq_cyc[0] : -1;
        checks++;
        if (first !== want) $display("FAIL busy_first_cwrite: got %0d want %0d", first, want);
        else passed++;
        checks++;
        if (drop_count !== 16'(drop_m))
            $display("FAIL busy_drops: got %0d want %0d", drop_count, drop_m);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c, n, want;
        for (int i = 0; i < 8; i++) wr(BASE + 7'(i), $urandom);
        clear_wq();
        wr(BASE + 7'd8, 32'h3);
        c = cyc;
        repeat (2) begin
            @(posedge clk); #1;
        end
        wr(BASE + 7'd6, $urandom);
        wr(BASE + 7'd1, $urandom);
        wr(BASE + 7'd3, $urandom);
        wr(BASE + 7'd8, 32'h3);
        wait_idle("b2b");
        n = wq_cyc.size();
        checks++;
        if (n !== 16) $display("FAIL b2b_count: got %0d want 16", n);
        else passed++;
        for (int k = 0; k < n && k < 16; k++) begin
            want = c + 2 + k + ((k >= 8) ? 2 : 0);
            checks++;
            if (wq_cyc[k] !== want || wq_st[k] !== 3'(k % 8))
                $display("FAIL b2b_slot%0d: cyc %0d st %0d want cyc %0d st %0d",
                         k, wq_cyc[k], wq_st[k], want, k % 8);
            else passed++;
            checks++;
            if (wq_d[k] !== exp_word(wq_st[k], wq_cyc[k]))
                $display("FAIL b2b_data%0d: got %h want %h",
                         k, wq_d[k], exp_word(wq_st[k], wq_cyc[k]));
            else passed++;
        end
    endtask

    task automatic test_match_debounce();
        bit evt, rx_exp;
        logic rx_obs;
        int ev_seen = 0;
        wr(BASE + 7'd8, 32'h2);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, evt, rx_exp, rx_obs);
            if (match_event === 1'b1) ev_seen++;
            checks++;
            if (match_event !== evt)
                $display("FAIL deb_event%0d: got %b want %b", k, match_event, evt);
            else passed++;
        end
        checks++;
        if (ev_seen !== 1 || match_count !== 16'(match_m))
            $display("FAIL deb_count1: events %0d count %0d want 1/%0d", ev_seen, match_count, match_m);
        else passed++;
        repeat (11) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        checks++;
        if (match_event !== evt || evt !== 1'b0)
            $display("FAIL deb_edge: got %b model %b want 0", match_event, evt);
        else passed++;
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        checks++;
        if (match_event !== 1'b0)
            $display("FAIL deb_novalid: got %b want 0", match_event);
        else passed++;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        checks++;
        if (match_event !== 1'b1 || match_count !== 16'd2)
            $display("FAIL deb_second: event %b count %0d want 1/2", match_event, match_count);
        else passed++;
    endtask

    task automatic test_random_traffic();
        bit evt, rx_exp, rx, v, m, ctl;
        logic rx_obs;
        logic [2:0] cb;
        for (int k = 0; k < 400; k++) begin
            rx = ($urandom % 3) == 0;
            v = $urandom % 2;
            m = $urandom % 2;
            ctl = ($urandom % 16) == 0;
            cb = {(($urandom % 4) == 0), (($urandom % 4) != 0), 1'b0};
            drive_cycle(rx, v, m, ctl, cb, evt, rx_exp, rx_obs);
            checks++;
            if (rx_obs !== rx_exp)
                $display("FAIL rnd_rxout%0d: got %b want %b", k, rx_obs, rx_exp);
            else passed++;
            checks++;
            if (match_event !== evt)
                $display("FAIL rnd_event%0d: got %b want %b", k, match_event, evt);
            else passed++;
            checks++;
            if (match_count !== 16'(match_m) || drop_count !== 16'(drop_m))
                $display("FAIL rnd_counts%0d: got %0d/%0d want %0d/%0d",
                         k, match_count, drop_count, match_m, drop_m);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        bit evt, rx_exp;
        logic rx_obs;
        int n;
        wr(BASE + 7'd8, 32'h0);
        n = 65535 - drop_m;
        rxstrobe_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rxstrobe_in = 1'b0;
        drop_m = 65535;
        checks++;
        if (drop_count !== 16'hFFFF) $display("FAIL sat_reach: got %h want FFFF", drop_count);
        else passed++;
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        checks++;
        if (drop_count !== 16'(drop_m)) $display("FAIL sat_hold: got %h want %h", drop_count, 16'(drop_m));
        else passed++;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 3'b100, evt, rx_exp, rx_obs);
        checks++;
        if (drop_count !== 16'(drop_m) || match_count !== 16'(match_m))
            $display("FAIL clr_wins: got %0d/%0d want %0d/%0d", drop_count, match_count, drop_m, match_m);
        else passed++;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, evt, rx_exp, rx_obs);
        checks++;
        if (drop_count !== 16'(drop_m)) $display("FAIL clr_after: got %0d want %0d", drop_count, drop_m);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int n = 0;
        for (int i = 0; i < 8; i++) wr(BASE + 7'(i), $urandom | 32'h1);
        wr(BASE + 7'd8, 32'h3);
        while (mf_cwrite !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mf_cwrite !== 1'b1) $display("FAIL abort_start: cwrite %b want 1", mf_cwrite);
        else passed++;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mf_cwrite, commit_busy, mf_cdata} !== 34'd0 || debugbus !== 16'd0)
            $display("FAIL abort_outputs: cw %b busy %b data %h dbg %h want 0",
                     mf_cwrite, commit_busy, mf_cdata, debugbus);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        lg_cyc.delete();
        lg_idx.delete();
        lg_d.delete();
        en_m = 1'b0;
        drop_m = 0;
        match_m = 0;
        fwd_since = 1000;
        clear_wq();
        wr(BASE + 7'd8, 32'h3);
        wait_idle("abort_recommit");
        checks++;
        if (wq_cyc.size() !== (FULL_LOAD ? 8 : 0))
            $display("FAIL abort_count: got %0d want %0d", wq_cyc.size(), FULL_LOAD ? 8 : 0);
        else passed++;
        for (int k = 0; k < wq_d.size(); k++) begin
            checks++;
            if (wq_d[k] !== exp_word(wq_st[k], wq_cyc[k]))
                $display("FAIL abort_data%0d: got %h want %h", k, wq_d[k], exp_word(wq_st[k], wq_cyc[k]));
            else passed++;
        end
    endtask

`ifdef MFCTRL_DIRTY_ONLY_EN
    task automatic test_dirty_only();
        int c, fall;
        clear_wq();
        wr(BASE + 7'd2, $urandom);
        wr(BASE + 7'd5, $urandom);
        wr(BASE + 7'd8, 32'h3);
        c = cyc;
        wait_idle("dirty");
        checks++;
        if (wq_cyc.size() !== 2) $display("FAIL dirty_count: got %0d want 2", wq_cyc.size());
        else passed++;
        if (wq_cyc.size() == 2) begin
            checks++;
            if (wq_st[0] !== 3'd2 || wq_st[1] !== 3'd5 || wq_cyc[0] !== c + 2 || wq_cyc[1] !== c + 3)
                $display("FAIL dirty_order: st %0d,%0d cyc %0d,%0d want 2,5 %0d,%0d",
                         wq_st[0], wq_st[1], wq_cyc[0], wq_cyc[1], c + 2, c + 3);
            else passed++;
            checks++;
            if (wq_d[0] !== exp_word(3'd2, wq_cyc[0]) || wq_d[1] !== exp_word(3'd5, wq_cyc[1]))
                $display("FAIL dirty_data: got %h,%h", wq_d[0], wq_d[1]);
            else passed++;
        end
        clear_wq();
        wr(BASE + 7'd8, 32'h3);
        c = cyc;
        wait_idle("dirty_empty");
        fall = cyc;
        checks++;
        if (wq_cyc.size() !== 0 || fall !== c + 2)
            $display("FAIL dirty_empty: writes %0d fall %0d want 0 %0d", wq_cyc.size(), fall, c + 2);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_commit();
`ifndef MFCTRL_DIRTY_ONLY_EN
        test_commit_during_activity();
        test_back_to_back();
`endif
        test_match_debounce();
        test_random_traffic();
        test_saturation();
        test_reset_abort();
`ifdef MFCTRL_DIRTY_ONLY_EN
        test_dirty_only();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
